// File: rtl/dlfloat_result_drain.sv
// dlfloat_result_drain: captures DLFloat16 MAC results into a small FIFO after the MAC
// pipeline latency and drains them byte-serially (low byte first) on a read-request handshake.
// Optional feature macro: DRAIN_FLAGS_EN adds is_zero / is_max flags for the presented entry.

module dlfloat_result_drain #(
   parameter int unsigned DEPTH = 4,   // FIFO entries, power of two, >= 2
   parameter int unsigned LAT   = 3,   // in_valid to mac_c latency, >= 1
   parameter int unsigned W     = 16   // result width, fixed for DLFloat16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   input  logic [W-1:0]             mac_c,
   input  logic                     rd_req,
   output logic [7:0]               out_byte,
   output logic                     out_valid,
   output logic                     out_hi,
   output logic                     full,
   output logic                     empty,
   output logic                     overflow,
`ifdef DRAIN_FLAGS_EN
   output logic                     is_zero,
   output logic                     is_max,
`endif
   output logic [$clog2(DEPTH):0]   count
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;
   localparam logic [CW-1:0] DepthC = CW'(DEPTH);

   typedef enum logic [1:0] {StIdle, StLo, StHi} state_e;

   state_e            state_q, state_d;
   logic [LAT-1:0]    vpipe_q, vpipe_d;
   logic [PW-1:0]     wr_ptr_q, rd_ptr_q;
   logic [CW-1:0]     count_q, count_d;
   logic              overflow_q, overflow_d;
   logic [W-1:0]      mem_q [DEPTH];
   logic [W-1:0]      head;
   logic              cap, pop, push_ok;

   // Valid shift register mirroring the MAC pipeline depth
   if (LAT == 1) begin : g_lat1
      assign vpipe_d = in_valid;
   end else begin : g_latn
      assign vpipe_d = {vpipe_q[LAT-2:0], in_valid};
   end

   assign cap  = vpipe_q[LAT-1];
   assign head = mem_q[rd_ptr_q];

   // Push/pop arbitration; a pop frees the slot a simultaneous push needs when full
   always_comb begin
      pop        = (state_q == StHi) && rd_req;
      push_ok    = cap && ((count_q < DepthC) || pop);
      count_d    = count_q + CW'(push_ok) - CW'(pop);
      overflow_d = overflow_q | (cap & ~push_ok);
   end

   // Pipeline, pointers, occupancy, sticky overflow and FSM state
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         vpipe_q    <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
         state_q    <= StIdle;
      end else begin
         vpipe_q    <= vpipe_d;
         count_q    <= count_d;
         overflow_q <= overflow_d;
         state_q    <= state_d;
         if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
      end
   end

   // FIFO storage; contents are don't-care until written, so no reset
   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wr_ptr_q] <= mac_c;
   end

   // Output FSM next state: low byte, then high byte, then pop
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (!empty) state_d = StLo;
         StLo:    if (rd_req) state_d = StHi;
         StHi:    if (rd_req) state_d = (count_d != '0) ? StLo : StIdle;
         default: state_d = StIdle;
      endcase
   end

   // Output decode from state and head entry
   always_comb begin
      out_byte  = 8'h00;
      out_valid = 1'b0;
      out_hi    = 1'b0;
      unique case (state_q)
         StLo: begin
            out_byte  = head[7:0];
            out_valid = 1'b1;
         end
         StHi: begin
            out_byte  = head[W-1:8];
            out_valid = 1'b1;
            out_hi    = 1'b1;
         end
         default: ;
      endcase
   end

   assign empty    = (count_q == '0);
   assign full     = (count_q == DepthC);
   assign overflow = overflow_q;
   assign count    = count_q;

`ifdef DRAIN_FLAGS_EN
   // Flags describe the presented entry only
   always_comb begin
      is_zero = out_valid && (head[14:0] == 15'h0000);
      is_max  = out_valid && (head[14:9] == 6'h3F);
   end
`endif

endmodule

// File: tb/tb_dlfloat_result_drain.sv
// Self-checking bench for dlfloat_result_drain: directed scenarios plus a randomized phase,
// compared every cycle against a queue-based reference model.

module tb_dlfloat_result_drain;

   localparam int unsigned DEPTH = 4;
   localparam int unsigned LAT   = 3;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        in_valid = 1'b0;
   logic [15:0] mac_c = 16'h0000;
   logic        rd_req = 1'b0;
   logic [7:0]  out_byte;
   logic        out_valid, out_hi, full, empty, overflow;
   logic [2:0]  count;
`ifdef DRAIN_FLAGS_EN
   logic        is_zero, is_max;
`endif

   dlfloat_result_drain #(.DEPTH(DEPTH), .LAT(LAT), .W(16)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .mac_c     (mac_c),
      .rd_req    (rd_req),
      .out_byte  (out_byte),
      .out_valid (out_valid),
      .out_hi    (out_hi),
      .full      (full),
      .empty     (empty),
      .overflow  (overflow),
`ifdef DRAIN_FLAGS_EN
      .is_zero   (is_zero),
      .is_max    (is_max),
`endif
      .count     (count)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // Reference model: in-flight valids, stored results, and which byte is being shown
   bit          pipe[$];
   logic [15:0] q[$];
   logic [15:0] feed[$];
   bit          pres, hi_m, ovf_m;

   function automatic void model_reset();
      pipe.delete();
      for (int i = 0; i < LAT; i++) pipe.push_back(1'b0);
      q.delete();
      pres  = 1'b0;
      hi_m  = 1'b0;
      ovf_m = 1'b0;
   endfunction

   function automatic void model_edge(bit iv, bit rr, logic [15:0] d);
      bit cap, pop;
      int sz0;
      cap = pipe.pop_front();
      pipe.push_back(iv);
      pop = pres && hi_m && rr;
      sz0 = q.size();
      if (pop) void'(q.pop_front());
      if (cap) begin
         if (sz0 < DEPTH || pop) q.push_back(d);
         else ovf_m = 1'b1;
      end
      if (!pres) pres = (sz0 > 0);
      else if (!hi_m) begin
         if (rr) hi_m = 1'b1;
      end else if (rr) begin
         hi_m = 1'b0;
         pres = (q.size() > 0);
      end
   endfunction

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_all();
      logic [7:0] eb;
      eb = 8'h00;
      if (pres) eb = hi_m ? q[0][15:8] : q[0][7:0];
      chk("out_valid", {15'd0, out_valid}, {15'd0, pres});
      chk("out_hi",    {15'd0, out_hi},    {15'd0, pres && hi_m});
      chk("out_byte",  {8'd0, out_byte},   {8'd0, eb});
      chk("count",     {13'd0, count},     16'(q.size()));
      chk("empty",     {15'd0, empty},     {15'd0, q.size() == 0});
      chk("full",      {15'd0, full},      {15'd0, q.size() == DEPTH});
      chk("overflow",  {15'd0, overflow},  {15'd0, ovf_m});
`ifdef DRAIN_FLAGS_EN
      chk("is_zero", {15'd0, is_zero}, {15'd0, pres && (q[0][14:0] == 15'd0)});
      chk("is_max",  {15'd0, is_max},  {15'd0, pres && (q[0][14:9] == 6'h3F)});
`endif
   endtask

   // One clock: drive inputs, advance model at the edge, check just after it
   task automatic cycle(input bit iv, input bit rr);
      logic [15:0] d;
      d = 16'($urandom);
      if (pipe[0] && feed.size() > 0) d = feed.pop_front();
      in_valid = iv;
      rd_req   = rr;
      mac_c    = d;
      @(posedge clk);
      if (!rst) model_reset();
      else model_edge(iv, rr, d);
      #1;
      check_all();
   endtask

   task automatic do_reset();
      rst = 1'b0;
      #1;
      model_reset();
      check_all();
      cycle(1'b0, 1'b0);
      rst = 1'b1;
      cycle(1'b0, 1'b0);
   endtask

   // Drain bytes, checking each presented byte before accepting it
   task automatic drain(input logic [15:0] vals[$]);
      foreach (vals[i]) begin
         chk("drain_lo", {8'd0, out_byte}, {8'd0, vals[i][7:0]});
         cycle(1'b0, 1'b1);
         chk("drain_hi", {8'd0, out_byte}, {8'd0, vals[i][15:8]});
         chk("drain_no55", {15'd0, out_byte == 8'h55}, 16'd0);
         cycle(1'b0, 1'b1);
      end
   endtask

   initial begin
      logic [15:0] vals[$];

      // Reset values
      #1;
      model_reset();
      check_all();
      chk("rst_empty", {15'd0, empty}, 16'd1);
      cycle(1'b0, 1'b0);
      rst = 1'b1;
      cycle(1'b0, 1'b0);

      // Single result
      feed.push_back(16'h3E00);
      cycle(1'b1, 1'b0);
      cycle(1'b0, 1'b0);
      cycle(1'b0, 1'b0);
      chk("t1_empty_before", {15'd0, empty}, 16'd1);
      cycle(1'b0, 1'b0);
      chk("t1_empty_after", {15'd0, empty}, 16'd0);
      cycle(1'b0, 1'b0);
      chk("t1_lo_byte", {8'd0, out_byte}, 16'h0000);
      chk("t1_lo_hi", {15'd0, out_hi}, 16'd0);
      cycle(1'b0, 1'b1);
      chk("t1_hi_byte", {8'd0, out_byte}, 16'h003E);
      chk("t1_hi_hi", {15'd0, out_hi}, 16'd1);
      cycle(1'b0, 1'b1);
      chk("t1_idle_valid", {15'd0, out_valid}, 16'd0);
      chk("t1_idle_empty", {15'd0, empty}, 16'd1);

      // Burst fill to full, then drain in order
      vals = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
      foreach (vals[i]) feed.push_back(vals[i]);
      for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0);
      for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0);
      chk("t2_full", {15'd0, full}, 16'd1);
      chk("t2_count", {13'd0, count}, 16'd4);
      chk("t2_ovf", {15'd0, overflow}, 16'd0);
      drain(vals);
      chk("t2_empty", {15'd0, empty}, 16'd1);

      // Overflow: fifth result dropped, flag sticky
      vals = '{16'hA1A2, 16'hB1B2, 16'hC1C2, 16'hD1D2};
      foreach (vals[i]) feed.push_back(vals[i]);
      feed.push_back(16'h5555);
      for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0);
      for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0);
      chk("t3_ovf", {15'd0, overflow}, 16'd1);
      chk("t3_count", {13'd0, count}, 16'd4);
      drain(vals);
      chk("t3_ovf_sticky", {15'd0, overflow}, 16'd1);

      // Simultaneous push and pop at full
      do_reset();
      vals = '{16'h0102, 16'h0304, 16'h0506, 16'h0708};
      foreach (vals[i]) feed.push_back(vals[i]);
      for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0);
      for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0);
      feed.push_back(16'h9A9B);
      cycle(1'b1, 1'b1);
      cycle(1'b0, 1'b0);
      cycle(1'b0, 1'b0);
      chk("t4_full_pre", {13'd0, count}, 16'd4);
      cycle(1'b0, 1'b1);
      chk("t4_count", {13'd0, count}, 16'd4);
      chk("t4_ovf", {15'd0, overflow}, 16'd0);
      vals = '{16'h0304, 16'h0506, 16'h0708, 16'h9A9B};
      drain(vals);

      // Reset mid-drain: in HI, two stored, one in flight
      vals = '{16'h1234, 16'h5678};
      foreach (vals[i]) feed.push_back(vals[i]);
      cycle(1'b1, 1'b0);
      cycle(1'b1, 1'b0);
      for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0);
      feed.push_back(16'hEEEE);
      cycle(1'b1, 1'b1);
      chk("t5_in_hi", {15'd0, out_hi}, 16'd1);
      #2;
      rst = 1'b0;
      #1;
      model_reset();
      feed.delete();
      check_all();
      chk("t5_rst_valid", {15'd0, out_valid}, 16'd0);
      chk("t5_rst_byte", {8'd0, out_byte}, 16'd0);
      chk("t5_rst_empty", {15'd0, empty}, 16'd1);
      cycle(1'b0, 1'b0);
      rst = 1'b1;
      for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0);
      chk("t5_no_capture", {13'd0, count}, 16'd0);

`ifdef DRAIN_FLAGS_EN
      feed.push_back(16'h8000);
      feed.push_back(16'h7E01);
      cycle(1'b1, 1'b0);
      cycle(1'b1, 1'b0);
      for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0);
      chk("f_zero_z", {15'd0, is_zero}, 16'd1);
      chk("f_zero_m", {15'd0, is_max}, 16'd0);
      cycle(1'b0, 1'b1);
      cycle(1'b0, 1'b1);
      chk("f_max_m", {15'd0, is_max}, 16'd1);
      chk("f_max_z", {15'd0, is_zero}, 16'd0);
      cycle(1'b0, 1'b1);
      cycle(1'b0, 1'b1);
`endif

      // Randomized traffic against the model
      for (int i = 0; i < 400; i++) begin
         cycle($urandom_range(0, 9) < 4, $urandom_range(0, 1) == 1);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
